fifo_wide_narrow: RTL

Single-clock width-converting FIFO. Words of WR_WIDTH bits are written in and read out as RD_WIDTH-bit units. It generalises the fixed 32-in/8-out block RAM buffer with configurable widths, depth and lane order, and adds flow control (full/empty/level) plus sticky error flags. It sits between wide producers (packet/DMA engines) and byte-oriented consumers (serialisers, protocol parsers).

---
 rtl/fifo_wide_narrow.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fifo_wide_narrow.sv
// Width-converting FIFO on a single clock. WR_WIDTH-bit words are written
// in and read out as RD_WIDTH-bit lanes, in the order set by BIG_ENDIAN.
// The level, empty and full flags are registered, and two sticky flags
// record rejected writes and rejected reads. The storage array has no
// reset and a registered read, so it can map onto block RAM.
module fifo_wide_narrow #(
    parameter int WR_WIDTH   = 32,
    parameter int RD_WIDTH   = 8,
    parameter int DEPTH      = 512,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                                               clk_in,
    input  logic                                               rst_in,
    input  logic                                               flush_in,
    input  logic                                               wr_en_in,
    input  logic [WR_WIDTH-1:0]                                wr_d_in,
    output logic                                               full_out,
    input  logic                                               rd_en_in,
    output logic [RD_WIDTH-1:0]                                rd_d_out,
    output logic                                               rd_valid_out,
    output logic                                               empty_out,
    output logic [$clog2(DEPTH*(WR_WIDTH/RD_WIDTH)):0]         count_out,
    output logic                                               overflow_out,
    output logic                                               underflow_out
);

    localparam int R  = WR_WIDTH / RD_WIDTH;     // read lanes per word
    localparam int AW = $clog2(DEPTH);           // word address bits
    localparam int LW = $clog2(R);               // lane index bits
    localparam int CW = $clog2(DEPTH * R) + 1;   // unit pointer / count bits
    localparam int SW = (LW > 0) ? LW : 1;       // lane select register width

    localparam logic [AW:0]   WP_ONE      = (AW+1)'(1);
    localparam logic [CW-1:0] RP_ONE      = CW'(1);
    localparam logic [CW-1:0] FULL_THRESH = CW'((DEPTH - 1) * R);

    // Pointers: wp counts words and rp counts read units. Each pointer has
    // one extra bit, so a full FIFO and an empty FIFO give different counts.
    logic [AW:0]   wp_q, wp_d;
    logic [CW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [SW-1:0] lane_q, lane_d;
    logic          seen_q, seen_d;   // a read has completed since reset

    logic          wr_acc;
    logic          rd_acc;
    logic [SW-1:0] rd_lane;

    logic [WR_WIDTH-1:0] mem [DEPTH];
    logic [WR_WIDTH-1:0] word_q;
    logic [RD_WIDTH-1:0] lanes [R];

    // The lane being read is the low bits of the unit pointer.
    generate
        if (LW > 0) begin : g_lane_bits
            assign rd_lane = rp_q[LW-1:0];
        end else begin : g_lane_single
            assign rd_lane = '0;
        end
    endgenerate

    // Split the registered word into lanes. Lane 0 is the lane read first.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lanes
            if (BIG_ENDIAN != 0) begin : g_be
                assign lanes[gi] = word_q[WR_WIDTH-1-gi*RD_WIDTH -: RD_WIDTH];
            end else begin : g_le
                assign lanes[gi] = word_q[gi*RD_WIDTH +: RD_WIDTH];
            end
        end
    endgenerate

    // Accept requests against the registered flags. Flush wins over both
    // requests and returns the FIFO to its reset state.
    always_comb begin
        wr_acc  = wr_en_in && !full_q  && !flush_in;
        rd_acc  = rd_en_in && !empty_q && !flush_in;
        wp_d    = wp_q;
        rp_d    = rp_q;
        ovf_d   = ovf_q | (wr_en_in & full_q);
        unf_d   = unf_q | (rd_en_in & empty_q);
        lane_d  = lane_q;
        seen_d  = seen_q | rd_acc;
        valid_d = rd_acc;
        if (wr_acc) begin
            wp_d = wp_q + WP_ONE;
        end
        if (rd_acc) begin
            rp_d   = rp_q + RP_ONE;
            lane_d = rd_lane;
        end
        if (flush_in) begin
            wp_d  = '0;
            rp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        count_d = (CW'(wp_d) << LW) - rp_d;
        empty_d = (count_d == '0);
        full_d  = (count_d > FULL_THRESH);
    end

    // Control state, cleared asynchronously by reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            lane_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            lane_q  <= lane_d;
            seen_q  <= seen_d;
        end
    end

    // Storage: a write port and a registered read of the whole word. The
    // read enable is the accepted read, so word_q holds between reads.
    always_ff @(posedge clk_in) begin
        if (wr_acc) begin
            mem[wp_q[AW-1:0]] <= wr_d_in;
        end
        if (rd_acc) begin
            word_q <= mem[rp_q[LW +: AW]];
        end
    end

    // Before the first read after reset, the read data reads as zero. After
    // that it holds the last lane delivered, including across a flush.
    assign rd_d_out      = seen_q ? lanes[lane_q] : '0;
    assign rd_valid_out  = valid_q;
    assign count_out     = count_q;
    assign empty_out     = empty_q;
    assign full_out      = full_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;

endmodule
